// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream multiplexer with a built-in
// round-robin or fixed-priority arbiter and a single registered output stage.
// The winning channel index travels with the data on out_sel.
module rr_stream_mux #(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int PRIO_MODE = 0,
    localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] grant;
    logic [N-1:0]     grant_oh;
    logic [WIDTH-1:0] grant_data;
    logic             found;
    logic             load;
    int               base;

    assign load = !valid_q || out_ready;

    // Arbiter: search from the pointer up to N-1 first, then wrap to 0.
    // Fixed priority simply starts the search at 0.
    always_comb begin
        grant      = '0;
        grant_oh   = '0;
        grant_data = '0;
        found      = 1'b0;
        base       = (PRIO_MODE != 0) ? 0 : int'(ptr_q);
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (i >= base)) begin
                found      = 1'b1;
                grant      = SEL_W'(i);
                grant_oh   = N'(1) << i;
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                found      = 1'b1;
                grant      = SEL_W'(i);
                grant_oh   = N'(1) << i;
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept only when the output register can take a word; forced low in reset.
    always_comb begin
        in_ready = (!rst && load) ? grant_oh : '0;
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (found) begin
                data_d  = grant_data;
                sel_d   = grant;
                valid_d = 1'b1;
                if (PRIO_MODE == 0) begin
                    ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Output stage and pointer; reset drops any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a round-robin N=4 instance driven from a
// vector table, plus fixed-priority, N=3 and N=1 instances and an async
// reset-during-stall sequence.
module tb_rr_stream_mux;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // Round-robin, N=4, WIDTH=32
    logic [127:0] rr_data;
    logic [3:0]   rr_valid;
    logic [3:0]   rr_ready;
    logic [31:0]  rr_odata;
    logic [1:0]   rr_osel;
    logic         rr_ovalid;
    logic         rr_oready;

    // Fixed priority, N=4, WIDTH=32
    logic [127:0] fp_data;
    logic [3:0]   fp_valid;
    logic [3:0]   fp_ready;
    logic [31:0]  fp_odata;
    logic [1:0]   fp_osel;
    logic         fp_ovalid;
    logic         fp_oready;

    // Round-robin, N=3, WIDTH=8
    logic [23:0]  n3_data;
    logic [2:0]   n3_valid;
    logic [2:0]   n3_ready;
    logic [7:0]   n3_odata;
    logic [1:0]   n3_osel;
    logic         n3_ovalid;
    logic         n3_oready;

    // N=1, WIDTH=8
    logic [7:0]   n1_data;
    logic [0:0]   n1_valid;
    logic [0:0]   n1_ready;
    logic [7:0]   n1_odata;
    logic [0:0]   n1_osel;
    logic         n1_ovalid;
    logic         n1_oready;

    rr_stream_mux #(.WIDTH(32), .N(4), .PRIO_MODE(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(rr_data), .in_valid(rr_valid),
        .in_ready(rr_ready), .out_data(rr_odata), .out_sel(rr_osel),
        .out_valid(rr_ovalid), .out_ready(rr_oready)
    );

    rr_stream_mux #(.WIDTH(32), .N(4), .PRIO_MODE(1)) u_fp4 (
        .clk(clk), .rst(rst), .in_data(fp_data), .in_valid(fp_valid),
        .in_ready(fp_ready), .out_data(fp_odata), .out_sel(fp_osel),
        .out_valid(fp_ovalid), .out_ready(fp_oready)
    );

    rr_stream_mux #(.WIDTH(8), .N(3), .PRIO_MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(n3_data), .in_valid(n3_valid),
        .in_ready(n3_ready), .out_data(n3_odata), .out_sel(n3_osel),
        .out_valid(n3_ovalid), .out_ready(n3_oready)
    );

    rr_stream_mux #(.WIDTH(8), .N(1), .PRIO_MODE(0)) u_n1 (
        .clk(clk), .rst(rst), .in_data(n1_data), .in_valid(n1_valid),
        .in_ready(n1_ready), .out_data(n1_odata), .out_sel(n1_osel),
        .out_valid(n1_ovalid), .out_ready(n1_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;
        logic [127:0] data;
        logic         ordy;
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        logic [1:0]   exp_sel;
        logic [31:0]  exp_data;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] DA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] DB = {32'hA3, 32'h55, 32'hA1, 32'hA0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rr_data   = DA;   rr_valid = '0; rr_oready = 1'b1;
        fp_data   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        fp_valid  = '0;   fp_oready = 1'b1;
        n3_data   = {8'h32, 8'h31, 8'h30};
        n3_valid  = '0;   n3_oready = 1'b1;
        n1_data   = 8'h00; n1_valid = '0; n1_oready = 1'b1;

        // rotation, sparse wrap, idle gap, backpressure
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
        vecs.push_back('{4'b0100, DA, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2});
        vecs.push_back('{4'b0011, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});
        vecs.push_back('{4'b0011, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1});
        vecs.push_back('{4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1});
        vecs.push_back('{4'b1111, DB, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h55});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h55});
        vecs.push_back('{4'b1111, DB, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3});
        vecs.push_back('{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0});

        // Reset state
        #2;
        chk("rst_ovalid", 32'(rr_ovalid), 32'd0);
        chk("rst_odata", rr_odata, 32'd0);
        chk("rst_in_ready", 32'(rr_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            rr_valid  = vecs[k].valid;
            rr_data   = vecs[k].data;
            rr_oready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", k), 32'(rr_ready), 32'(vecs[k].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", k), 32'(rr_ovalid), 32'(vecs[k].exp_ov));
            chk($sformatf("v%0d_out_sel", k), 32'(rr_osel), 32'(vecs[k].exp_sel));
            chk($sformatf("v%0d_out_data", k), rr_odata, vecs[k].exp_data);
        end

        // Async reset while stalled with a held word
        @(negedge clk);
        rr_valid  = 4'b1111;
        rr_data   = DA;
        rr_oready = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_hold_valid", 32'(rr_ovalid), 32'd1);
        chk("stall_hold_data", rr_odata, 32'hA0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ovalid", 32'(rr_ovalid), 32'd0);
        chk("arst_osel", 32'(rr_osel), 32'd0);
        chk("arst_odata", rr_odata, 32'd0);
        chk("arst_in_ready", 32'(rr_ready), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rr_oready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(rr_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_sel", 32'(rr_osel), 32'd0);
        chk("post_rst_data", rr_odata, 32'hA0);
        @(negedge clk);
        rr_valid = '0;

        // Fixed priority: channel 1 wins over 3 until it drops
        fp_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fp%0d_in_ready", i), 32'(fp_ready), 32'b0010);
            @(posedge clk);
            #1;
            chk($sformatf("fp%0d_sel", i), 32'(fp_osel), 32'd1);
            chk($sformatf("fp%0d_data", i), fp_odata, 32'hB1);
            @(negedge clk);
        end
        fp_valid = 4'b1000;
        #1;
        chk("fp_drop_in_ready", 32'(fp_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("fp_drop_sel", 32'(fp_osel), 32'd3);
        chk("fp_drop_data", fp_odata, 32'hB3);
        @(negedge clk);
        fp_valid = '0;

        // N=3 rotation wraps 2 -> 0
        n3_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n3_%0d_sel", i), 32'(n3_osel), 32'(i % 3));
            chk($sformatf("n3_%0d_data", i), 32'(n3_odata), 32'h30 + 32'(i % 3));
            @(negedge clk);
        end
        n3_valid = '0;

        // N=1 registered pipe
        for (int i = 1; i <= 3; i++) begin
            n1_data  = 8'(i * 8'h11);
            n1_valid = 1'b1;
            #1;
            chk($sformatf("n1_%0d_in_ready", i), 32'(n1_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("n1_%0d_valid", i), 32'(n1_ovalid), 32'd1);
            chk($sformatf("n1_%0d_sel", i), 32'(n1_osel), 32'd0);
            chk($sformatf("n1_%0d_data", i), 32'(n1_odata), 32'(i * 8'h11));
            @(negedge clk);
        end
        n1_valid = '0;
        n1_data  = 8'hEE;
        @(posedge clk);
        #1;
        chk("n1_idle_valid", 32'(n1_ovalid), 32'd0);
        chk("n1_idle_data", 32'(n1_odata), 32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N:1 stream multiplexer with valid/ready handshaking, built-in arbitration and a registered output stage. It replaces fixed-select 2:1 muxing wherever several producers share one consumer, such as the I-fetch/D-access request merge into the memory port or the writeback source merge. Selection comes from the arbiter, not from an external select line. The chosen channel index is forwarded with the data.

Parameters:
WIDTH, 32, data width per channel in bits
N, 4, number of input channels (N >= 1)
SEL_W, (N>1 ? $clog2(N) : 1), width of the channel-index output; derived, not to be overridden
PRIO_MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i holds a valid word
in_ready  output  N  channel i word accepted this cycle (one-hot or zero)
out_data  output  WIDTH  registered selected word
out_sel  output  SEL_W  index of the channel that supplied out_data
out_valid  output  1  out_data/out_sel hold a valid word
out_ready  input  1  downstream accepts the word this cycle

Behaviour:
- Reset (async, while rst=1): out_valid=0, out_data=0, out_sel=0, RR pointer ptr=0, in_ready=0 (forced combinationally). Any word in the output register is dropped.
- Transfer rules: input transfer on channel i when in_valid[i] && in_ready[i]; output transfer when out_valid && out_ready.
- load = !out_valid || out_ready. This is combinational and allows full throughput of 1 word/cycle.
- Grant when PRIO_MODE=0: g = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
- Grant when PRIO_MODE=1: g = lowest i with in_valid[i]=1; ptr is held at 0 and ignored.
- in_ready[i] = !rst && load && (i == g) && |in_valid. At most one bit is set, and never a bit whose in_valid is 0.
- On a rising edge with load=1 and |in_valid=1:
  - out_data <= channel g word, out_sel <= g, out_valid <= 1.
  - In RR mode, ptr <= (g == N-1) ? 0 : g+1.
- On a rising edge with load=1 and in_valid=0 (all bits): out_valid <= 0; out_data and out_sel hold their old values; ptr holds.
- With load=0 (stall: out_valid && !out_ready):
  - out_data, out_sel, out_valid and ptr are all stable.
  - in_ready = 0.
- Latency: a word accepted at edge k is visible on out_* after edge k. There is no combinational path from in_data to out_data.
- Simultaneous output drain and input accept in the same cycle is normal back-to-back operation; no bubble is inserted.
- ptr advances only on an accepted input transfer. Valid inputs that are not granted do not affect it.
- Upstream protocol requirement: once asserted, in_valid[i] stays high with stable data until accepted. The block does not check this.
- Fairness: in RR mode with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive accepts.
- N=1: out_sel is tied to 0, ptr stays 0, and the block degenerates to a registered single-stage pipe.
- N not a power of two: ptr must never take values >= N. The wrap rule above guarantees this.

Test Plan:
1. Reset check. Assert rst mid-stall with out_valid=1 (N=4, WIDTH=32). Required: out_valid, out_sel, out_data and in_ready go to 0 immediately, without waiting for a clk edge. After release, the first grant with all valid goes to channel 0.
2. Round-robin rotation. Hold in_valid=4'b1111 with data 0xA0..0xA3 and out_ready=1. Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data matching 0xA0,0xA1,..., out_valid continuously 1.
3. Sparse wrap. Set ptr=3 (after granting channel 2), then in_valid=4'b0011. Required: grant channel 0, then channel 1 on the next cycle; channel 3 is not granted.
4. Backpressure. Hold out_ready=0 for 5 cycles with out_valid=1 (word 0x55 from channel 2) and all inputs valid. Required: in_ready=0 and out_data=0x55, out_sel=2 stable throughout. When out_ready rises, the next word (from channel 3) appears one edge later, with no bubble.
5. Fixed priority. Set PRIO_MODE=1 and in_valid=4'b1010 held. Required: channel 1 is granted every cycle and channel 3 is never granted until in_valid[1] drops.
6. Idle gap and boundaries. Drop all in_valid for one cycle, then test the extremes:
   - Required: out_valid drops to 0 for one cycle, with out_data holding its last value.
   - N=3: ptr wraps 2->0.
   - N=1: out_sel stays 0 and data passes through with 1-cycle latency.
